// File: rtl/dual_issue_fetch_queue_pkg.sv
// Shared types and constants for the dual-issue fetch queue.
// The entry type is reused by the decode stage.
package dual_issue_fetch_queue_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [1:0] ISSUE_NONE = 2'd0;
   localparam logic [1:0] ISSUE_ONE  = 2'd1;
   localparam logic [1:0] ISSUE_TWO  = 2'd2;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/dual_issue_fetch_queue_if.sv
// Fetch-side write and decode-side read bundle of the fetch queue.
// master = fetch/decode driving side, slave = the queue.
interface dual_issue_fetch_queue_if #(
   parameter int DEPTH = 8,
   parameter int IW    = 32,
   parameter int PW    = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          flush;
   logic          wr_valid;
   logic          wr_ready;
   logic [IW-1:0] wr_instr;
   logic [PW-1:0] wr_pc;
   logic          out0_valid;
   logic [IW-1:0] out0_instr;
   logic [PW-1:0] out0_pc;
   logic          out1_valid;
   logic [IW-1:0] out1_instr;
   logic [PW-1:0] out1_pc;
   logic [1:0]    issue_cnt;
   logic [CW-1:0] count;

   modport master (
      output flush, wr_valid, wr_instr, wr_pc, issue_cnt,
      input  wr_ready, out0_valid, out0_instr, out0_pc,
      input  out1_valid, out1_instr, out1_pc, count
   );

   modport slave (
      input  flush, wr_valid, wr_instr, wr_pc, issue_cnt,
      output wr_ready, out0_valid, out0_instr, out0_pc,
      output out1_valid, out1_instr, out1_pc, count
   );

endinterface

// File: rtl/dual_issue_fetch_queue_ram.sv
// Entry storage: one synchronous write port, two async read ports.
// Contents are not reset; validity is tracked by the occupancy count.
module fetch_queue_ram #(
   parameter int DEPTH = 8,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [W-1:0]             i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr0,
   input  logic [$clog2(DEPTH)-1:0] i_raddr1,
   output logic [W-1:0]             o_rdata0,
   output logic [W-1:0]             o_rdata1
);

   logic [W-1:0] r_mem [DEPTH];

   // store the incoming entry at the write address
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata0 = r_mem[i_raddr0];
   assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/dual_issue_fetch_queue.sv
// Fetch buffer: one write per cycle, up to two in-order retires.
// Flush and reset both empty the queue and drop same-cycle traffic.
import dual_issue_fetch_queue_pkg::*;

module dual_issue_fetch_queue #(
   parameter int DEPTH = 8,
   parameter int IW    = INSTR_W,
   parameter int PW    = PC_W
) (
   input  logic                     clk,
   input  logic                     reset,
   dual_issue_fetch_queue_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = PW + IW;

   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [1:0]    w_req;
   logic [CW-1:0] w_pop;
   logic          w_full;
   logic          w_write;
   logic [AW-1:0] w_rd1;
   logic [EW-1:0] w_wdata;
   logic [EW-1:0] w_rdata0;
   logic [EW-1:0] w_rdata1;

   // clamp the issue request to 2, then to what is actually held
   always_comb begin
      w_req = ISSUE_TWO;
      case (bus.issue_cnt)
         ISSUE_NONE: w_req = ISSUE_NONE;
         ISSUE_ONE:  w_req = ISSUE_ONE;
         default:    w_req = ISSUE_TWO;
      endcase
      w_pop = (CW'(w_req) < r_count) ? CW'(w_req) : r_count;
   end

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_write = bus.wr_valid && !w_full && !bus.flush && !reset;
   assign w_rd1   = r_head + AW'(1);
   assign w_wdata = {bus.wr_pc, bus.wr_instr};

   // pointer and occupancy update; reset and flush empty the queue
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + w_pop[AW-1:0];
         r_tail  <= r_tail + AW'(w_write);
         r_count <= r_count + CW'(w_write) - w_pop;
      end
   end

   fetch_queue_ram #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_ram (
      .clk      (clk),
      .i_we     (w_write),
      .i_waddr  (r_tail),
      .i_wdata  (w_wdata),
      .i_raddr0 (r_head),
      .i_raddr1 (w_rd1),
      .o_rdata0 (w_rdata0),
      .o_rdata1 (w_rdata1)
   );

   assign bus.wr_ready   = !w_full;
   assign bus.count      = r_count;
   assign bus.out0_valid = (r_count != '0);
   assign bus.out1_valid = (r_count >= CW'(2));
   assign bus.out0_pc    = w_rdata0[EW-1:IW];
   assign bus.out0_instr = w_rdata0[IW-1:0];
   assign bus.out1_pc    = w_rdata1[EW-1:IW];
   assign bus.out1_instr = w_rdata1[IW-1:0];

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Bench for the dual-issue fetch queue: vector table, directed
// corner sequences and random traffic against a queue model.
import dual_issue_fetch_queue_pkg::*;

module tb_dual_issue_fetch_queue;

   localparam int DEPTH = 8;

   logic clk;
   logic reset;

   dual_issue_fetch_queue_if #(.DEPTH(DEPTH), .IW(32), .PW(32)) bus ();

   dual_issue_fetch_queue #(.DEPTH(DEPTH), .IW(32), .PW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   fq_entry_t mq[$];

   typedef struct {
      logic        rs;
      logic        fl;
      logic        wv;
      logic [31:0] pc;
      logic [1:0]  iss;
      int          cnt;
      logic        v0;
      logic        v1;
      logic        rdy;
      logic [31:0] pc0;
      logic [31:0] pc1;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]} ^ 32'h5A3C_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_model();
      int n;
      n = mq.size();
      chk("count", 32'(bus.count), 32'(n));
      chk("wr_ready", 32'(bus.wr_ready), 32'(n != DEPTH));
      chk("out0_valid", 32'(bus.out0_valid), 32'(n >= 1));
      chk("out1_valid", 32'(bus.out1_valid), 32'(n >= 2));
      if (n >= 1) begin
         chk("out0_pc", bus.out0_pc, mq[0].pc);
         chk("out0_instr", bus.out0_instr, mq[0].instr);
      end
      if (n >= 2) begin
         chk("out1_pc", bus.out1_pc, mq[1].pc);
         chk("out1_instr", bus.out1_instr, mq[1].instr);
      end
   endtask

   task automatic cycle(input logic rs, input logic fl, input logic wv,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic [1:0] iss);
      int  pop;
      bit  acc;
      fq_entry_t e;
      reset         = rs;
      bus.flush     = fl;
      bus.wr_valid  = wv;
      bus.wr_pc     = pc;
      bus.wr_instr  = ins;
      bus.issue_cnt = iss;
      acc = wv && (mq.size() < DEPTH);
      @(posedge clk);
      if (rs || fl) begin
         mq.delete();
      end else begin
         pop = (iss == 2'd3) ? 2 : int'(iss);
         if (pop > mq.size()) pop = mq.size();
         repeat (pop) void'(mq.pop_front());
         if (acc) begin
            e.pc    = pc;
            e.instr = ins;
            mq.push_back(e);
         end
      end
      #1;
      check_model();
   endtask

   task automatic step(input logic wv, input logic [31:0] pc,
                       input logic [1:0] iss);
      cycle(1'b0, 1'b0, wv, pc, instr_of(pc), iss);
   endtask

   function automatic vec_t mk(input logic rs, input logic wv,
                               input logic [31:0] pc, input logic [1:0] iss,
                               input int cnt, input logic [31:0] pc0,
                               input logic [31:0] pc1);
      vec_t v;
      v.rs  = rs;
      v.fl  = 1'b0;
      v.wv  = wv;
      v.pc  = pc;
      v.iss = iss;
      v.cnt = cnt;
      v.v0  = (cnt >= 1);
      v.v1  = (cnt >= 2);
      v.rdy = (cnt != DEPTH);
      v.pc0 = pc0;
      v.pc1 = pc1;
      return v;
   endfunction

   initial begin
      reset         = 1'b1;
      bus.flush     = 1'b0;
      bus.wr_valid  = 1'b0;
      bus.wr_pc     = '0;
      bus.wr_instr  = '0;
      bus.issue_cnt = 2'd0;

      // reset with a write pending, fill to full, drop 9th, drain by twos
      tbl.push_back(mk(1'b1, 1'b1, 32'h3C, 2'd0, 0, 32'h0, 32'h0));
      tbl.push_back(mk(1'b1, 1'b1, 32'h3C, 2'd0, 0, 32'h0, 32'h0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1'b0, 1'b1, 32'(4 * i), 2'd0, i + 1,
                          32'h00, 32'h04));
      tbl.push_back(mk(1'b0, 1'b1, 32'h20, 2'd0, 8, 32'h00, 32'h04));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0, 2'd2, 6, 32'h08, 32'h0C));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0, 2'd2, 4, 32'h10, 32'h14));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0, 2'd2, 2, 32'h18, 32'h1C));
      tbl.push_back(mk(1'b0, 1'b0, 32'h0, 2'd2, 0, 32'h0, 32'h0));

      mq.delete();
      foreach (tbl[i]) begin
         cycle(tbl[i].rs, tbl[i].fl, tbl[i].wv, tbl[i].pc,
               instr_of(tbl[i].pc), tbl[i].iss);
         chk("tbl_count", 32'(bus.count), 32'(tbl[i].cnt));
         chk("tbl_v0", 32'(bus.out0_valid), 32'(tbl[i].v0));
         chk("tbl_v1", 32'(bus.out1_valid), 32'(tbl[i].v1));
         chk("tbl_ready", 32'(bus.wr_ready), 32'(tbl[i].rdy));
         if (tbl[i].v0) chk("tbl_pc0", bus.out0_pc, tbl[i].pc0);
         if (tbl[i].v1) chk("tbl_pc1", bus.out1_pc, tbl[i].pc1);
      end

      // wrap: park one entry (0x40) in slot 7, then write+pop together
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      for (int i = 0; i < 7; i++) step(1'b1, 32'h300 + 32'(4 * i), 2'd0);
      step(1'b1, 32'h40, 2'd2);
      step(1'b0, 32'h0, 2'd2);
      step(1'b0, 32'h0, 2'd2);
      step(1'b0, 32'h0, 2'd1);
      chk("wrap_prime_cnt", 32'(bus.count), 32'd1);
      chk("wrap_prime_pc0", bus.out0_pc, 32'h40);
      step(1'b1, 32'h44, 2'd1);
      chk("wrap_wp_cnt", 32'(bus.count), 32'd1);
      chk("wrap_wp_pc0", bus.out0_pc, 32'h44);
      step(1'b1, 32'h48, 2'd0);
      chk("wrap_pair_pc0", bus.out0_pc, 32'h44);
      chk("wrap_pair_pc1", bus.out1_pc, 32'h48);

      // over-issue with a single entry
      step(1'b0, 32'h0, 2'd2);
      step(1'b1, 32'h80, 2'd0);
      step(1'b0, 32'h0, 2'd2);
      chk("clamp_cnt", 32'(bus.count), 32'd0);
      step(1'b1, 32'h84, 2'd0);
      chk("clamp_next_pc0", bus.out0_pc, 32'h84);
      chk("clamp_next_v0", 32'(bus.out0_valid), 32'd1);

      // flush with five held, a write and an issue in the same cycle
      for (int i = 0; i < 4; i++) step(1'b1, 32'h90 + 32'(4 * i), 2'd0);
      chk("flush_pre_cnt", 32'(bus.count), 32'd5);
      cycle(1'b0, 1'b1, 1'b1, 32'h100, instr_of(32'h100), 2'd2);
      chk("flush_cnt", 32'(bus.count), 32'd0);
      chk("flush_v0", 32'(bus.out0_valid), 32'd0);
      chk("flush_v1", 32'(bus.out1_valid), 32'd0);
      step(1'b1, 32'h200, 2'd0);
      chk("flush_next_pc0", bus.out0_pc, 32'h200);
      chk("flush_next_cnt", 32'(bus.count), 32'd1);

      // random traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         logic rs;
         logic fl;
         logic wv;
         rs = ($urandom_range(0, 99) == 0);
         fl = ($urandom_range(0, 39) == 0);
         wv = ($urandom_range(0, 3) != 0);
         cycle(rs, fl, wv, $urandom, $urandom,
               2'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_issue_fetch_queue.md
Name: dual_issue_fetch_queue

Overview:
- Instruction fetch buffer between the instruction memory fetch stage and the dual-issue decode stage of the pipelined MIPS core.
- Accepts at most one 32-bit instruction and its PC per cycle from fetch (writer side).
- Presents the two oldest entries to decode, which retires 0, 1 or 2 of them per cycle (reader side).
- A flush (branch/jump redirect) discards all buffered entries.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- IW, 32, instruction width in bits.
- PW, 32, PC width in bits.

Ports:
- clk  input  1  single core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries this cycle.
- wr_valid  input  1  fetch presents an instruction.
- wr_ready  output  1  queue can accept a write this cycle.
- wr_instr  input  IW  fetched instruction word.
- wr_pc  input  PW  PC of the fetched instruction.
- out0_valid  output  1  oldest entry present.
- out0_instr  output  IW  oldest instruction.
- out0_pc  output  PW  oldest PC.
- out1_valid  output  1  second-oldest entry present.
- out1_instr  output  IW  second-oldest instruction.
- out1_pc  output  PW  second-oldest PC.
- issue_cnt  input  2  entries decode consumes this cycle (0, 1 or 2; 3 is treated as 2).
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - head pointer, tail pointer (log2(DEPTH) bits each, wrap modulo DEPTH).
  - count register.
  - DEPTH-entry storage of {pc, instr}.
- Reset (synchronous, active-high) and flush have identical effect:
  - head = tail = count = 0.
  - Storage contents are don't-care.
  - On the next cycle: out0_valid = out1_valid = 0, count = 0, wr_ready = 1.
  - Both override any simultaneous write or issue: the write is dropped and the issue is ignored.
- wr_ready = (count != DEPTH). It is combinational from registered count and does not depend on same-cycle issue, so a full queue never accepts a write even while a pop happens.
- Write occurs when wr_valid && wr_ready && !flush:
  - storage[tail] <= {wr_pc, wr_instr}.
  - tail <= tail + 1.
- Effective pop: pop = min(issue_cnt clamped to 2, count). Over-issue is clamped silently, never underflowing.
  - head <= head + pop, modulo DEPTH.
- count <= count + write - pop. Write and pop in the same cycle are legal, including at count = 1 with a pop of 1.
- Read outputs are combinational from registered state:
  - out0 = storage[head], out1 = storage[head+1 mod DEPTH].
  - out0_valid = (count >= 1), out1_valid = (count >= 2).
  - Invalid out*_instr/pc are don't-care; the bench must not check them.
- Latency: an instruction written in cycle N is visible at out0/out1 in cycle N+1. No bypass from wr_* to out*.
- Ordering:
  - Strict FIFO in program order.
  - out0 is always older than out1.
  - A pair straddling the wrap (head = DEPTH-1) reads storage[DEPTH-1] and storage[0].
- No internal FSM beyond the pointers and count. Invariant: tail == head + count (mod DEPTH).

Decomposition:
- Shared package holds:
  - IW/PW defaults (INSTR_W = 32, PC_W = 32).
  - Issue-count encodings: ISSUE_NONE = 0, ISSUE_ONE = 1, ISSUE_TWO = 2.
  - The packed {pc, instr} entry type, reused by decode.
- One natural sub-module: fetch_queue_ram, a DEPTH x (PW+IW) storage with one synchronous write port and two asynchronous read ports (addresses head, head+1).
- Pointer and count logic stay in the top module.

Test Plan:
1. Reset check: assert reset 2 cycles with wr_valid = 1 -> count = 0, out0_valid = out1_valid = 0, wr_ready = 1. Nothing written.
2. Fill: write PCs 0x00,0x04,...,0x1C (8 writes), issue_cnt = 0 -> count reaches 8 and wr_ready = 0. A 9th write with PC 0x20 is dropped; out0_pc = 0x00, out1_pc = 0x04.
3. Dual issue: from full, issue_cnt = 2 for 4 cycles -> out0_pc/out1_pc sequence 0x00/0x04, 0x08/0x0C, 0x10/0x14, 0x18/0x1C. Then count = 0.
4. Wrap plus simultaneous write/pop: prime head to 7 and hold 1 entry (PC 0x40). In one cycle write PC 0x44 with issue_cnt = 1 -> count stays 1 and out0_pc = 0x44, read from slot 0. Next write gives out1 from slot 1.
5. Over-issue clamp: count = 1 (PC 0x80), issue_cnt = 2 -> count = 0, head advances by 1. Next write (PC 0x84) appears at out0 the following cycle.
6. Flush mid-stream: count = 5 with wr_valid = 1 (PC 0x100), flush = 1, issue_cnt = 2 -> next cycle count = 0, both valids 0. PC 0x100 is absent; a subsequent write of 0x200 appears at out0.
